// File: rtl/uart_host_controller_pkg.sv
// Shared types and constants for the UART host controller: FSM encodings, default frame
// length, baud selector codes and error-bit positions.
package uart_host_controller_pkg;

    typedef enum logic [1:0] {
        StTxIdle   = 2'b00,
        StTxLaunch = 2'b01,
        StTxFrame  = 2'b10,
        StTxDone   = 2'b11
    } tx_state_e;

    typedef enum logic {
        StRxIdle = 1'b0,
        StRxAck  = 1'b1
    } rx_state_e;

    // Start + 8 data + stop
    localparam int unsigned DefaultFrameTicks = 10;

    localparam logic [1:0] BaudSel0 = 2'b00;
    localparam logic [1:0] BaudSel1 = 2'b01;
    localparam logic [1:0] BaudSel2 = 2'b10;
    localparam logic [1:0] BaudSel3 = 2'b11;

    localparam int unsigned ErrParityBit  = 0;
    localparam int unsigned ErrFramingBit = 1;
    localparam int unsigned ErrOverrunBit = 2;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin arbiter: searches upward from LastGrant+1 with wrap and returns
// a one-hot grant (all zero when nothing requests).
module round_robin_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         Requests,
    input  logic [$clog2(N)-1:0] LastGrant,
    output logic [N-1:0]         Grant
);

    always_comb begin
        int unsigned idx;
        logic        found;
        Grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            idx = (32'(LastGrant) + off) % N;
            if (!found && Requests[idx[$clog2(N)-1:0]]) begin
                Grant[idx[$clog2(N)-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_host_controller.sv
// Arbitrates client bytes onto the UART transmit path paced by the baud Tick, drains the
// UART receive side into a one-entry valid/ready buffer and owns the baud-selection register.
module uart_host_controller
    import uart_host_controller_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned FRAME_TICKS = DefaultFrameTicks
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_CLIENTS-1:0]   TxRequest,
    input  logic [8*NUM_CLIENTS-1:0] TxData,
    output logic [NUM_CLIENTS-1:0]   TxGrant,
    output logic [NUM_CLIENTS-1:0]   TxDone,
    output logic                     TxBusy,
    output logic [7:0]               RxData,
    output logic [2:0]               RxErrors,
    output logic                     RxValid,
    input  logic                     RxReady,
    input  logic                     ConfigWrite,
    input  logic [1:0]               ConfigBaud,
    output logic [1:0]               UartBaudSelection,
    output logic [7:0]               UartInputData,
    output logic                     UartSendCommand,
    input  logic                     UartTick,
    input  logic                     UartHostInterrupt,
    input  logic [7:0]               UartOutputData,
    input  logic [2:0]               UartErrors,
    output logic                     UartHostAcknowledge
);

    localparam int unsigned GrantW = $clog2(NUM_CLIENTS);
    localparam int unsigned CountW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CountW-1:0] LastTick = CountW'(FRAME_TICKS - 1);

    tx_state_e              tx_state_q, tx_state_d;
    rx_state_e              rx_state_q, rx_state_d;
    logic                   tick_q;
    logic                   tick_rise;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] done_q, done_d;
    logic                   busy_q, busy_d;
    logic                   send_q, send_d;
    logic [7:0]             data_q, data_d;
    logic [GrantW-1:0]      last_q, last_d;
    logic [CountW-1:0]      count_q, count_d;
    logic [1:0]             baud_q, baud_d;
    logic                   pend_q, pend_d;
    logic [1:0]             pend_baud_q, pend_baud_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic [2:0]             rx_err_q, rx_err_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   ack_q, ack_d;

    logic [NUM_CLIENTS-1:0] arb_grant;
    logic [GrantW-1:0]      win_idx;
    logic [7:0]             win_byte;
    logic                   rx_free;

    assign tick_rise = UartTick & ~tick_q;

    round_robin_arbiter #(
        .N (NUM_CLIENTS)
    ) u_arbiter (
        .Requests  (TxRequest),
        .LastGrant (last_q),
        .Grant     (arb_grant)
    );

    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_grant[i]) begin
                win_idx  = GrantW'(i);
                win_byte = TxData[8*i +: 8];
            end
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        grant_d     = grant_q;
        done_d      = '0;
        send_d      = send_q;
        data_d      = data_q;
        last_d      = last_q;
        count_d     = count_q;
        baud_d      = baud_q;
        pend_d      = pend_q;
        pend_baud_d = pend_baud_q;
        unique case (tx_state_q)
            StTxIdle: begin
                // A pending baud change takes this IDLE cycle; arbitration waits one cycle.
                if (pend_q) begin
                    baud_d = pend_baud_q;
                    pend_d = 1'b0;
                end else if (|TxRequest) begin
                    grant_d    = arb_grant;
                    data_d     = win_byte;
                    last_d     = win_idx;
                    send_d     = 1'b1;
                    tx_state_d = StTxLaunch;
                end
            end
            StTxLaunch: begin
                if (tick_rise) begin
                    send_d     = 1'b0;
                    count_d    = '0;
                    tx_state_d = StTxFrame;
                end
            end
            StTxFrame: begin
                if (tick_rise) begin
                    if (count_q == LastTick) begin
                        done_d     = grant_q;
                        tx_state_d = StTxDone;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StTxDone: begin
                grant_d    = '0;
                tx_state_d = StTxIdle;
            end
            default: tx_state_d = StTxIdle;
        endcase
        // A write in the same cycle as an apply stays pending for the next IDLE.
        if (ConfigWrite) begin
            pend_d      = 1'b1;
            pend_baud_d = ConfigBaud;
        end
        busy_d = (tx_state_d != StTxIdle);
    end

    assign rx_free = ~rx_valid_q | RxReady;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = rx_valid_q;
        ack_d      = ack_q;
        if (rx_valid_q && RxReady) begin
            rx_valid_d = 1'b0;
        end
        unique case (rx_state_q)
            StRxIdle: begin
                if (UartHostInterrupt && rx_free) begin
                    rx_data_d  = UartOutputData;
                    rx_err_d   = UartErrors;
                    rx_valid_d = 1'b1;
                    ack_d      = 1'b1;
                    rx_state_d = StRxAck;
                end
            end
            StRxAck: begin
                if (!UartHostInterrupt) begin
                    ack_d      = 1'b0;
                    rx_state_d = StRxIdle;
                end
            end
            default: rx_state_d = StRxIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            tx_state_q  <= StTxIdle;
            rx_state_q  <= StRxIdle;
            tick_q      <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            send_q      <= 1'b0;
            data_q      <= '0;
            last_q      <= GrantW'(NUM_CLIENTS - 1);
            count_q     <= '0;
            baud_q      <= BaudSel0;
            pend_q      <= 1'b0;
            pend_baud_q <= BaudSel0;
            rx_data_q   <= '0;
            rx_err_q    <= '0;
            rx_valid_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            tick_q      <= UartTick;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            send_q      <= send_d;
            data_q      <= data_d;
            last_q      <= last_d;
            count_q     <= count_d;
            baud_q      <= baud_d;
            pend_q      <= pend_d;
            pend_baud_q <= pend_baud_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign TxGrant             = grant_q;
    assign TxDone              = done_q;
    assign TxBusy              = busy_q;
    assign UartSendCommand     = send_q;
    assign UartInputData       = data_q;
    assign UartBaudSelection   = baud_q;
    assign RxData              = rx_data_q;
    assign RxErrors            = rx_err_q;
    assign RxValid             = rx_valid_q;
    assign UartHostAcknowledge = ack_q;

endmodule

// File: tb/tb_uart_host_controller.sv
// Directed bench for uart_host_controller: arbitration order, frame pacing, baud config,
// mid-frame reset and the receive handshake including the full-buffer case.
module tb_uart_host_controller;

    localparam int unsigned FRAME_TICKS = 10;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  TxRequest = '0;
    logic [31:0] TxData = '0;
    logic [3:0]  TxGrant;
    logic [3:0]  TxDone;
    logic        TxBusy;
    logic [7:0]  RxData;
    logic [2:0]  RxErrors;
    logic        RxValid;
    logic        RxReady = 1'b0;
    logic        ConfigWrite = 1'b0;
    logic [1:0]  ConfigBaud = '0;
    logic [1:0]  UartBaudSelection;
    logic [7:0]  UartInputData;
    logic        UartSendCommand;
    logic        UartTick = 1'b0;
    logic        UartHostInterrupt = 1'b0;
    logic [7:0]  UartOutputData = '0;
    logic [2:0]  UartErrors = '0;
    logic        UartHostAcknowledge;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_host_controller #(
        .NUM_CLIENTS (4),
        .FRAME_TICKS (FRAME_TICKS)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .TxRequest           (TxRequest),
        .TxData              (TxData),
        .TxGrant             (TxGrant),
        .TxDone              (TxDone),
        .TxBusy              (TxBusy),
        .RxData              (RxData),
        .RxErrors            (RxErrors),
        .RxValid             (RxValid),
        .RxReady             (RxReady),
        .ConfigWrite         (ConfigWrite),
        .ConfigBaud          (ConfigBaud),
        .UartBaudSelection   (UartBaudSelection),
        .UartInputData       (UartInputData),
        .UartSendCommand     (UartSendCommand),
        .UartTick            (UartTick),
        .UartHostInterrupt   (UartHostInterrupt),
        .UartOutputData      (UartOutputData),
        .UartErrors          (UartErrors),
        .UartHostAcknowledge (UartHostAcknowledge)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One Tick rising edge seen by the DUT; returns in the cycle after that edge with Tick low.
    task automatic tick_edge();
        UartTick = 1'b1;
        step();
        UartTick = 1'b0;
    endtask

    // Entered in the LAUNCH cycle; returns in the IDLE cycle following DONE.
    task automatic run_frame(input logic [3:0] g, input logic [7:0] d, input int cfg_k,
                             input logic [1:0] b);
        check("grant_launch", 32'(TxGrant), 32'(g));
        check("send_launch", 32'(UartSendCommand), 32'd1);
        check("data_launch", 32'(UartInputData), 32'(d));
        check("busy_launch", 32'(TxBusy), 32'd1);
        for (int k = 0; k < int'(FRAME_TICKS); k++) begin
            tick_edge();
            if (k == cfg_k) begin
                ConfigWrite = 1'b1;
                ConfigBaud  = 2'b10;
            end
            check("send_frame", 32'(UartSendCommand), 32'd0);
            check("nodone_frame", 32'(TxDone), 32'd0);
            check("data_frame", 32'(UartInputData), 32'(d));
            check("baud_frame", 32'(UartBaudSelection), 32'(b));
            step();
            ConfigWrite = 1'b0;
        end
        tick_edge();
        check("done_pulse", 32'(TxDone), 32'(g));
        check("grant_done", 32'(TxGrant), 32'(g));
        check("data_done", 32'(UartInputData), 32'(d));
        check("baud_done", 32'(UartBaudSelection), 32'(b));
        step();
        check("done_clear", 32'(TxDone), 32'd0);
        check("grant_clear", 32'(TxGrant), 32'd0);
        check("busy_idle", 32'(TxBusy), 32'd0);
    endtask

    initial begin
        // Reset values
        step();
        step();
        Reset = 1'b0;
        check("rst_grant", 32'(TxGrant), 32'd0);
        check("rst_done", 32'(TxDone), 32'd0);
        check("rst_busy", 32'(TxBusy), 32'd0);
        check("rst_send", 32'(UartSendCommand), 32'd0);
        check("rst_data", 32'(UartInputData), 32'd0);
        check("rst_baud", 32'(UartBaudSelection), 32'd0);
        check("rst_rxvalid", 32'(RxValid), 32'd0);
        check("rst_rxdata", 32'(RxData), 32'd0);
        check("rst_rxerr", 32'(RxErrors), 32'd0);
        check("rst_ack", 32'(UartHostAcknowledge), 32'd0);

        // Single request from client 2, byte 0xA5
        TxData    = 32'h44A5_2211;
        TxRequest = 4'b0100;
        step();
        TxRequest = 4'b0000;
        TxData    = 32'hDEAD_BEEF;
        check("c2_grant", 32'(TxGrant), 32'b0100);
        step();
        check("c2_send_hold", 32'(UartSendCommand), 32'd1);
        check("c2_data_hold", 32'(UartInputData), 32'hA5);
        run_frame(4'b0100, 8'hA5, -1, 2'b00);

        // Reset during FRAME; last grant was 2, so without reset client 3 would win next
        TxData    = 32'h44A5_2211;
        TxRequest = 4'b0100;
        step();
        TxRequest = 4'b0000;
        check("rstf_grant", 32'(TxGrant), 32'b0100);
        tick_edge();
        step();
        tick_edge();
        step();
        check("rstf_busy_pre", 32'(TxBusy), 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("rstf_grant0", 32'(TxGrant), 32'd0);
        check("rstf_send0", 32'(UartSendCommand), 32'd0);
        check("rstf_done0", 32'(TxDone), 32'd0);
        check("rstf_busy0", 32'(TxBusy), 32'd0);
        check("rstf_data0", 32'(UartInputData), 32'd0);
        for (int k = 0; k < 12; k++) begin
            tick_edge();
            check("rstf_nodone", 32'(TxDone), 32'd0);
            step();
        end

        // All four clients continuously: 0,1,2,3,0
        TxRequest = 4'b1111;
        step();
        run_frame(4'b0001, 8'h11, -1, 2'b00);
        step();
        run_frame(4'b0010, 8'h22, -1, 2'b00);
        step();
        run_frame(4'b0100, 8'hA5, -1, 2'b00);
        step();
        run_frame(4'b1000, 8'h44, -1, 2'b00);
        step();
        TxRequest = 4'b0000;
        run_frame(4'b0001, 8'h11, -1, 2'b00);

        // Baud change written mid-frame, applied in IDLE, next grant delayed one cycle
        TxRequest = 4'b1000;
        step();
        run_frame(4'b1000, 8'h44, 3, 2'b00);
        check("cfg_idle_baud", 32'(UartBaudSelection), 32'd0);
        check("cfg_idle_grant", 32'(TxGrant), 32'd0);
        step();
        check("cfg_applied", 32'(UartBaudSelection), 32'b10);
        check("cfg_grant_delay", 32'(TxGrant), 32'd0);
        check("cfg_send_delay", 32'(UartSendCommand), 32'd0);
        step();
        TxRequest = 4'b0000;
        run_frame(4'b1000, 8'h44, -1, 2'b10);

        // RX handshake
        UartOutputData    = 8'h3C;
        UartErrors        = 3'b000;
        UartHostInterrupt = 1'b1;
        step();
        check("rx_valid", 32'(RxValid), 32'd1);
        check("rx_data", 32'(RxData), 32'h3C);
        check("rx_err", 32'(RxErrors), 32'd0);
        check("rx_ack", 32'(UartHostAcknowledge), 32'd1);
        step();
        check("rx_ack_hold", 32'(UartHostAcknowledge), 32'd1);
        UartHostInterrupt = 1'b0;
        step();
        check("rx_ack_drop", 32'(UartHostAcknowledge), 32'd0);
        check("rx_valid_hold", 32'(RxValid), 32'd1);
        RxReady = 1'b1;
        step();
        RxReady = 1'b0;
        check("rx_consumed", 32'(RxValid), 32'd0);

        // RX buffer full: second byte waits unacknowledged
        UartErrors        = 3'b010;
        UartHostInterrupt = 1'b1;
        step();
        UartHostInterrupt = 1'b0;
        check("rxf_first", 32'(RxData), 32'h3C);
        check("rxf_first_err", 32'(RxErrors), 32'b010);
        step();
        check("rxf_ack_drop", 32'(UartHostAcknowledge), 32'd0);
        UartOutputData    = 8'h55;
        UartErrors        = 3'b101;
        UartHostInterrupt = 1'b1;
        step();
        check("rxf_no_ack", 32'(UartHostAcknowledge), 32'd0);
        check("rxf_keep_data", 32'(RxData), 32'h3C);
        check("rxf_keep_err", 32'(RxErrors), 32'b010);
        step();
        check("rxf_no_ack2", 32'(UartHostAcknowledge), 32'd0);
        RxReady = 1'b1;
        step();
        RxReady = 1'b0;
        check("rxf_swap_data", 32'(RxData), 32'h55);
        check("rxf_swap_err", 32'(RxErrors), 32'b101);
        check("rxf_swap_valid", 32'(RxValid), 32'd1);
        check("rxf_swap_ack", 32'(UartHostAcknowledge), 32'd1);
        UartHostInterrupt = 1'b0;
        step();
        check("rxf_ack_end", 32'(UartHostAcknowledge), 32'd0);
        RxReady = 1'b1;
        step();
        RxReady = 1'b0;
        check("rxf_drained", 32'(RxValid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
